// File: rtl/vector_mac_pkg.sv
// rtl/vector_mac_pkg.sv - width derivation, saturation bounds and lane slicing for the MAC PE
package vector_mac_pkg;

    function automatic int acc_width(input int lanes, input int width_mdata, input int width_guard);
        return width_mdata + $clog2(lanes) + width_guard;
    endfunction

    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/fixedpoint_round_sat.sv
// rtl/fixedpoint_round_sat.sv - half-up rounding right shift with saturation and clip flag
module fixedpoint_round_sat
    import vector_mac_pkg::*;
#(
    parameter int WIDTH_IN       = 42,
    parameter int WIDTH_OUT      = 16,
    parameter int WIDTH_FRACTION = 9
) (
    input  logic signed [WIDTH_IN-1:0]  value_i,
    output logic        [WIDTH_OUT-1:0] data_o,
    output logic                        sat_o
);
    // One extra bit so adding the rounding constant can never wrap.
    localparam int RW = WIDTH_IN + 1;
    localparam logic signed [RW-1:0] ROUND   = RW'(longint'(1) <<< (WIDTH_FRACTION - 1));
    localparam logic signed [RW-1:0] SAT_MAX = RW'(sat_max(WIDTH_OUT));
    localparam logic signed [RW-1:0] SAT_MIN = RW'(sat_min(WIDTH_OUT));

    logic signed [RW-1:0] biased;
    logic signed [RW-1:0] shifted;

    always_comb begin
        biased  = {value_i[WIDTH_IN-1], value_i} + ROUND;
        shifted = biased >>> WIDTH_FRACTION;
        if (shifted > SAT_MAX) begin
            data_o = SAT_MAX[WIDTH_OUT-1:0];
            sat_o  = 1'b1;
        end else if (shifted < SAT_MIN) begin
            data_o = SAT_MIN[WIDTH_OUT-1:0];
            sat_o  = 1'b1;
        end else begin
            data_o = shifted[WIDTH_OUT-1:0];
            sat_o  = 1'b0;
        end
    end

endmodule

// File: rtl/vector_mac_pe.sv
// rtl/vector_mac_pe.sv - pipelined multi-lane fixed-point dot-product processing element
module vector_mac_pe #(
    parameter int LANES          = 4,
    parameter int WIDTH_DATA     = 16,
    parameter int WIDTH_MDATA    = 32,
    parameter int WIDTH_INTEGER  = 6,
    parameter int WIDTH_FRACTION = 9,
    parameter int WIDTH_GUARD    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic                        in_last_i,
    input  logic [LANES*WIDTH_DATA-1:0] data_a_i,
    input  logic [LANES*WIDTH_DATA-1:0] data_b_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [WIDTH_DATA-1:0]       data_o,
    output logic                        sat_o
);
    import vector_mac_pkg::*;

    localparam int WIDTH_ACC = acc_width(LANES, WIDTH_MDATA, WIDTH_GUARD);

    logic en;

    logic signed [WIDTH_MDATA-1:0] prod_d [LANES];
    logic signed [WIDTH_MDATA-1:0] prod_q [LANES];
    logic                          v1_q, l1_q;

    logic signed [WIDTH_ACC-1:0]   sum_d, sum_q;
    logic                          v2_q, l2_q;

    logic signed [WIDTH_ACC-1:0]   acc_d, acc_q;
    logic                          first_d, first_q;
    logic                          v3_q, l3_q;

    logic [WIDTH_DATA-1:0]         fmt_data;
    logic                          fmt_sat;
    logic [WIDTH_DATA-1:0]         data_q;
    logic                          sat_q;
    logic                          out_valid_q;

    // The whole pipeline stalls together while a result waits for its consumer.
    assign en          = !out_valid_q || out_ready_i;
    assign in_ready_o  = en;
    assign out_valid_o = out_valid_q;
    assign data_o      = data_q;
    assign sat_o       = sat_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [WIDTH_DATA-1:0] a_s, b_s;
        assign a_s       = data_a_i[lane_lsb(k, WIDTH_DATA) +: WIDTH_DATA];
        assign b_s       = data_b_i[lane_lsb(k, WIDTH_DATA) +: WIDTH_DATA];
        assign prod_d[k] = WIDTH_MDATA'(a_s) * WIDTH_MDATA'(b_s);
    end

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < LANES; k++) begin
            sum_d = sum_d + WIDTH_ACC'(prod_q[k]);
        end
    end

    always_comb begin
        acc_d   = acc_q;
        first_d = first_q;
        if (v2_q) begin
            acc_d   = first_q ? sum_q : acc_q + sum_q;
            first_d = l2_q;
        end
    end

    fixedpoint_round_sat #(
        .WIDTH_IN       (WIDTH_ACC),
        .WIDTH_OUT      (WIDTH_DATA),
        .WIDTH_FRACTION (WIDTH_FRACTION)
    ) u_fmt (
        .value_i (acc_q),
        .data_o  (fmt_data),
        .sat_o   (fmt_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LANES; k++) prod_q[k] <= '0;
            v1_q        <= 1'b0;
            l1_q        <= 1'b0;
            sum_q       <= '0;
            v2_q        <= 1'b0;
            l2_q        <= 1'b0;
            acc_q       <= '0;
            first_q     <= 1'b1;
            v3_q        <= 1'b0;
            l3_q        <= 1'b0;
            data_q      <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            prod_q      <= prod_d;
            v1_q        <= in_valid_i;
            l1_q        <= in_valid_i && in_last_i;
            sum_q       <= sum_d;
            v2_q        <= v1_q;
            l2_q        <= l1_q;
            acc_q       <= acc_d;
            first_q     <= first_d;
            v3_q        <= v2_q;
            l3_q        <= l2_q;
            // A new result may replace the one being handed off on the same edge.
            out_valid_q <= v3_q && l3_q;
            if (v3_q && l3_q) begin
                data_q <= fmt_data;
                sat_q  <= fmt_sat;
            end
        end
    end

endmodule

// File: tb/tb_vector_mac_pe.sv
// tb/tb_vector_mac_pe.sv - directed self-checking bench for vector_mac_pe
module tb_vector_mac_pe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        in_last_i;
    logic [63:0] data_a_i;
    logic [63:0] data_b_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] data_o;
    logic        sat_o;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    vector_mac_pe dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_last_i   (in_last_i),
        .data_a_i    (data_a_i),
        .data_b_i    (data_b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .data_o      (data_o),
        .sat_o       (sat_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rep(input logic [15:0] x);
        return {4{x}};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [63:0] a, input logic [63:0] b, input logic last);
        int n = 0;
        while (!in_ready_o && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("beat_ready_timeout", 32'(in_ready_o), 32'd1);
        in_valid_i = 1'b1;
        in_last_i  = last;
        data_a_i   = a;
        data_b_i   = b;
        step();
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [15:0] exp_data, input logic exp_sat);
        int n = 0;
        while (!out_valid_o && n < 20) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid_o), 32'd1);
        check({tag, "_data"}, 32'(data_o), 32'(exp_data));
        check({tag, "_sat"}, 32'(sat_o), 32'(exp_sat));
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        in_valid_i  = 1'b0;
        in_last_i   = 1'b0;
        data_a_i    = '0;
        data_b_i    = '0;
        out_ready_i = 1'b1;
        step();
        step();
        check("rst_in_ready", 32'(in_ready_o), 32'd1);
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_sat", 32'(sat_o), 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_in_ready", 32'(in_ready_o), 32'd1);

        // Single beat, 4 x (1.0 * 1.0) = 4.0, with exact latency.
        beat(rep(16'h0200), rep(16'h0200), 1'b1);
        check("lat_n0", 32'(out_valid_o), 32'd0);
        step();
        check("lat_n1", 32'(out_valid_o), 32'd0);
        step();
        check("lat_n2", 32'(out_valid_o), 32'd0);
        step();
        check("lat_n3_valid", 32'(out_valid_o), 32'd1);
        check("lat_n3_data", 32'(data_o), 32'h0800);
        check("lat_n3_sat", 32'(sat_o), 32'd0);
        step();
        check("handshake_clear", 32'(out_valid_o), 32'd0);

        // Two beats of -1.0 * 1.0 per lane -> -8.0.
        beat(rep(16'hFE00), rep(16'h0200), 1'b0);
        beat(rep(16'hFE00), rep(16'h0200), 1'b1);
        wait_result("neg8", 16'hF000, 1'b0);

        wait_result_sat: begin
            beat(rep(16'h3FFF), rep(16'h3FFF), 1'b1);
            wait_result("sat_pos", 16'h7FFF, 1'b1);
            beat(rep(16'h3FFF), rep(16'hC001), 1'b1);
            wait_result("sat_neg", 16'h8000, 1'b1);
        end

        // Exact bounds are reachable without clipping.
        beat({48'h0, 16'h7FFF}, {48'h0, 16'h0200}, 1'b1);
        wait_result("max_exact", 16'h7FFF, 1'b0);
        beat({16'h8000, 48'h0}, {16'h0200, 48'h0}, 1'b1);
        wait_result("min_exact", 16'h8000, 1'b0);
        beat({32'h0, 16'h7FFF, 16'h7FFF}, {32'h0, 16'h0200, 16'h0200}, 1'b1);
        wait_result("max_over", 16'h7FFF, 1'b1);

        // Rounding: +0.5 LSB rounds up, -0.5 LSB rounds up to zero, just below half truncates.
        beat({48'h0, 16'h0001}, {48'h0, 16'h0100}, 1'b1);
        wait_result("round_half_pos", 16'h0001, 1'b0);
        beat({48'h0, 16'h0001}, {48'h0, 16'hFF00}, 1'b1);
        wait_result("round_half_neg", 16'h0000, 1'b0);
        beat({48'h0, 16'h0001}, {48'h0, 16'h00FF}, 1'b1);
        wait_result("round_below_half", 16'h0000, 1'b0);

        // Bubbles between beats leave the accumulator alone; next product restarts.
        beat(rep(16'h0200), rep(16'h0200), 1'b0);
        step();
        step();
        beat(rep(16'h0200), rep(16'h0200), 1'b1);
        wait_result("bubbles", 16'h1000, 1'b0);
        beat(rep(16'h0200), rep(16'h0200), 1'b1);
        wait_result("restart", 16'h0800, 1'b0);

        // Backpressure: result held, input stalled, nothing lost.
        out_ready_i = 1'b0;
        beat(rep(16'h0200), rep(16'h0200), 1'b1);
        beat(rep(16'hFE00), rep(16'h0200), 1'b1);
        for (int n = 0; n < 20 && !out_valid_o; n++) step();
        check("stall_first_valid", 32'(out_valid_o), 32'd1);
        in_valid_i = 1'b1;
        in_last_i  = 1'b1;
        data_a_i   = rep(16'h0200);
        data_b_i   = rep(16'h0400);
        for (int n = 0; n < 5; n++) begin
            step();
            check("stall_data", 32'(data_o), 32'h0800);
            check("stall_in_ready", 32'(in_ready_o), 32'd0);
            check("stall_valid", 32'(out_valid_o), 32'd1);
        end
        out_ready_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        check("stall_next_valid", 32'(out_valid_o), 32'd1);
        check("stall_next_data", 32'(data_o), 32'hF800);
        step();
        wait_result("stall_held_beat", 16'h1000, 1'b0);

        // Reset in mid-product discards the partial sum.
        beat(rep(16'h0200), rep(16'h0200), 1'b0);
        beat(rep(16'h0200), rep(16'h0200), 1'b0);
        rst = 1'b1;
        #2;
        check("midrst_in_ready", 32'(in_ready_o), 32'd1);
        check("midrst_out_valid", 32'(out_valid_o), 32'd0);
        step();
        rst = 1'b0;
        step();
        beat(rep(16'h0200), rep(16'h0200), 1'b1);
        wait_result("after_rst", 16'h0800, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vector_mac_pe.md
VECTOR_MAC_PE -- requirements
Module: vector_mac_pe

Interface
REQ-001 SHALL have parameter LANES, default 4: parallel multiply lanes per beat, power of two, 1..16.
REQ-002 SHALL have parameter WIDTH_DATA, default 16: signed fixed-point operand and result width.
REQ-003 SHALL have parameter WIDTH_MDATA, default 32: signed product width, equal to 2*WIDTH_DATA.
REQ-004 SHALL have parameter WIDTH_INTEGER, default 6: integer bits of the operand/result format, excluding sign.
REQ-005 SHALL have parameter WIDTH_FRACTION, default 9: fraction bits of the operand/result format; 1+WIDTH_INTEGER+WIDTH_FRACTION = WIDTH_DATA.
REQ-006 SHALL have parameter WIDTH_GUARD, default 8: accumulator headroom bits; accumulator width WIDTH_ACC = WIDTH_MDATA + log2(LANES) + WIDTH_GUARD.
REQ-007 Ports (clock and reset first):
  clk  in  1  clock, rising edge.
  rst  in  1  reset; one clock, reset is asynchronous and active-high.
  in_valid_i  in  1  input beat valid.
  in_ready_o  out  1  input beat accepted when in_valid_i and in_ready_o are both high.
  in_last_i  in  1  beat closes the current dot product.
  data_a_i  in  LANES*WIDTH_DATA  operand A; lane k occupies bits [k*WIDTH_DATA +: WIDTH_DATA].
  data_b_i  in  LANES*WIDTH_DATA  operand B, same packing.
  out_valid_o  out  1  result valid.
  out_ready_i  in  1  consumer accepts the result.
  data_o  out  WIDTH_DATA  formatted result.
  sat_o  out  1  data_o was clipped, qualified by out_valid_o.

Function
REQ-008 SHALL define a global advance enable en = !out_valid_o || out_ready_i; in_ready_o = en; every pipeline register SHALL update only while en is high.
REQ-009 S1 SHALL register the LANES signed products plus the beat's valid and last flags.
REQ-010 S2 SHALL register the sign-extended adder-tree sum of the S1 products, at WIDTH_ACC bits, plus the valid and last flags.
REQ-011 S3 SHALL hold a WIDTH_ACC accumulator.
  - If the S2 beat is valid and is the first beat of a product, the accumulator SHALL load the sum.
  - If the S2 beat is valid and is not the first beat, the accumulator SHALL add the sum.
  - A beat is first when it is the first beat since reset or the first beat after a last beat.
REQ-012 On the cycle S3 consumes a last beat, the formatted value SHALL be loaded into the output register and out_valid_o set in the same cycle.
  - Latency: a last beat accepted at edge N gives out_valid_o high after edge N+3.
REQ-013 Formatter (combinational) SHALL round the accumulator right by WIDTH_FRACTION, half-up: add 2^(WIDTH_FRACTION-1), then arithmetic shift.
REQ-014 The formatter SHALL saturate to [-2^(WIDTH_DATA-1), 2^(WIDTH_DATA-1)-1] and set sat_o when clipping occurs.
REQ-015 The output register SHALL hold data_o, sat_o and out_valid_o stable while out_valid_o && !out_ready_i.
REQ-016 out_valid_o SHALL clear on a handshake unless a new result loads on the same edge.
REQ-017 Beats with in_valid_i low SHALL be bubbles: they advance through the pipeline and leave the accumulator unchanged.
REQ-018 Accumulator wrap beyond WIDTH_ACC is undefined; WIDTH_GUARD SHALL cover 2^WIDTH_GUARD beats per product.
REQ-019 A product of a single beat with in_last_i high SHALL be legal.

Reset
REQ-020 rst SHALL asynchronously clear all valid/last flags, the accumulator, the first-beat flag (to 1), data_o (to 0), sat_o (to 0) and out_valid_o (to 0).
REQ-021 Reset in mid-product SHALL discard the partial sum; the next accepted beat SHALL start a new product.
REQ-022 in_ready_o SHALL be 1 during and directly after reset.

Structure
REQ-023 Package vector_mac_pkg SHALL hold the WIDTH_ACC derivation function, the saturation bounds and the lane slice helper.
REQ-024 Formatter SHALL be one sub-module, fixedpoint_round_sat (round plus saturate plus flag), instantiated once.

Verification (LANES=4, defaults; 0x0200 = 1.0)
REQ-025 One beat with all lanes A=B=0x0200 and last=1 -> after 3 cycles data_o=0x0800, sat_o=0.
REQ-026 Lanes A=0xFE00, B=0x0200, over two beats with last on the second -> data_o=0xF000 (-8.0).
REQ-027 All lanes A=B=0x3FFF, last=1 -> data_o=0x7FFF, sat_o=1; A=0x3FFF with B=0xC001 -> data_o=0x8000, sat_o=1.
REQ-028 Lane0 A=0x0001, B=0x0100, other lanes 0, last=1 -> data_o=0x0001 (half-up rounding).
REQ-029 out_ready_i held low for 5 cycles with a result pending -> data_o stable and in_ready_o=0; input held constant; no beat lost when ready returns.
REQ-030 rst pulsed after 2 of 4 beats, then one beat of 0x0200s with last -> data_o=0x0800.
